// File: rtl/ili9341_pkg.sv
// Shared opcodes, FSM state type and default panel geometry for the ILI9341
// command decoder and its address generator.
package ili9341_pkg;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 320;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

  // Coordinates are 9-bit and wrap naturally at 512.
  function automatic logic [8:0] wrap_inc(input logic [8:0] v);
    return v + 9'd1;
  endfunction

endpackage

// File: rtl/ili9341_addr_gen.sv
// Column/page window registers and the x/y write pointer that walks the
// window after each accepted pixel.
module ili9341_addr_gen
  import ili9341_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       win_rst,
  input  logic       set_col,
  input  logic       set_row,
  input  logic [8:0] win_start,
  input  logic [8:0] win_end,
  input  logic       load,
  input  logic       advance,
  output logic [8:0] x,
  output logic [8:0] y
);

  logic [8:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [8:0] x_q, x_d, y_q, y_d;

  always_comb begin
    sc_d = sc_q;
    ec_d = ec_q;
    sp_d = sp_q;
    ep_d = ep_q;
    x_d  = x_q;
    y_d  = y_q;
    if (win_rst) begin
      sc_d = 9'd0;
      ec_d = 9'(WIDTH - 1);
      sp_d = 9'd0;
      ep_d = 9'(HEIGHT - 1);
    end else begin
      if (set_col) begin
        sc_d = win_start;
        ec_d = win_end;
      end
      if (set_row) begin
        sp_d = win_start;
        ep_d = win_end;
      end
    end
    // An inverted window (start > end) simply counts up through 511 -> 0.
    if (load) begin
      x_d = sc_q;
      y_d = sp_q;
    end else if (advance) begin
      if (x_q == ec_q) begin
        x_d = sc_q;
        y_d = (y_q == ep_q) ? sp_q : wrap_inc(y_q);
      end else begin
        x_d = wrap_inc(x_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= 9'd0;
      ec_q <= 9'(WIDTH - 1);
      sp_q <= 9'd0;
      ep_q <= 9'(HEIGHT - 1);
      x_q  <= 9'd0;
      y_q  <= 9'd0;
    end else begin
      sc_q <= sc_d;
      ec_q <= ec_d;
      sp_q <= sp_d;
      ep_q <= ep_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/ili9341_cmd_decoder.sv
// ILI9341 command/data byte decoder: pops 9-bit FIFO entries, tracks the
// address window and emits RGB565 pixel writes. Define ILI_DISPCTL_EN to
// make DISPON/DISPOFF drive display_on (otherwise display_on is tied high).
module ili9341_cmd_decoder
  import ili9341_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_read_enable,
  input  logic [8:0]  fifo_read_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        display_on
);

  // pix_valid/pix_x/pix_y/pix_data form a valid/ready channel: once pix_valid
  // rises, all four hold until the cycle pix_ready is seen high.
  state_e      state_q, state_d;
  logic [8:0]  byte_q, byte_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [2:0]  pidx_q, pidx_d;
  logic [8:0]  pstart_q, pstart_d;
  logic        pend_hi_q, pend_hi_d;
  logic        half_q, half_d;
  logic [7:0]  hbyte_q, hbyte_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        win_rst, set_col, set_row, load, advance;
`ifdef ILI_DISPCTL_EN
  logic        disp_q, disp_d;
`endif

  assign fifo_read_enable = !rst && (state_q == ST_IDLE) && !fifo_empty && !pix_valid_q;

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    cmd_d       = cmd_q;
    pidx_d      = pidx_q;
    pstart_d    = pstart_q;
    pend_hi_d   = pend_hi_q;
    half_d      = half_q;
    hbyte_d     = hbyte_q;
    pix_data_d  = pix_data_q;
    advance     = pix_valid_q && pix_ready;
    pix_valid_d = pix_valid_q && !pix_ready;
    win_rst     = 1'b0;
    set_col     = 1'b0;
    set_row     = 1'b0;
    load        = 1'b0;
`ifdef ILI_DISPCTL_EN
    disp_d      = disp_q;
`endif
    case (state_q)
      ST_IDLE: if (fifo_read_enable) state_d = ST_WAIT;
      ST_WAIT: begin
        byte_d  = fifo_read_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (!byte_q[8]) begin
          cmd_d  = byte_q[7:0];
          pidx_d = 3'd0;
          half_d = 1'b0;
          case (byte_q[7:0])
            CMD_SWRESET: begin
              cmd_d   = CMD_NOP;
              win_rst = 1'b1;
`ifdef ILI_DISPCTL_EN
              disp_d  = 1'b0;
`endif
            end
            CMD_RAMWR:  load = 1'b1;
`ifdef ILI_DISPCTL_EN
            CMD_DISPON:  disp_d = 1'b1;
            CMD_DISPOFF: disp_d = 1'b0;
`endif
            default: ;
          endcase
        end else begin
          case (cmd_q)
            CMD_CASET, CMD_PASET: begin
              // Window bytes are staged; the registers change only on the 4th.
              if (pidx_q < 3'd4) begin
                pidx_d = pidx_q + 3'd1;
                case (pidx_q[1:0])
                  2'd0: pstart_d[8]   = byte_q[0];
                  2'd1: pstart_d[7:0] = byte_q[7:0];
                  2'd2: pend_hi_d     = byte_q[0];
                  default: begin
                    set_col = (cmd_q == CMD_CASET);
                    set_row = (cmd_q == CMD_PASET);
                  end
                endcase
              end
            end
            CMD_RAMWR: begin
              if (half_q) begin
                pix_data_d  = {hbyte_q, byte_q[7:0]};
                pix_valid_d = 1'b1;
                half_d      = 1'b0;
              end else begin
                hbyte_d = byte_q[7:0];
                half_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_q      <= 9'd0;
      cmd_q       <= CMD_NOP;
      pidx_q      <= 3'd0;
      pstart_q    <= 9'd0;
      pend_hi_q   <= 1'b0;
      half_q      <= 1'b0;
      hbyte_q     <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 16'd0;
`ifdef ILI_DISPCTL_EN
      disp_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      cmd_q       <= cmd_d;
      pidx_q      <= pidx_d;
      pstart_q    <= pstart_d;
      pend_hi_q   <= pend_hi_d;
      half_q      <= half_d;
      hbyte_q     <= hbyte_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
`ifdef ILI_DISPCTL_EN
      disp_q      <= disp_d;
`endif
    end
  end

  ili9341_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .win_rst   (win_rst),
    .set_col   (set_col),
    .set_row   (set_row),
    .win_start (pstart_q),
    .win_end   ({pend_hi_q, byte_q[7:0]}),
    .load      (load),
    .advance   (advance),
    .x         (pix_x),
    .y         (pix_y)
  );

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
`ifdef ILI_DISPCTL_EN
  assign display_on = disp_q;
`else
  assign display_on = 1'b1;
`endif

endmodule

// File: tb/tb_ili9341_cmd_decoder.sv
// Bench for ili9341_cmd_decoder: byte-stream reference model, FIFO/sink
// emulation, per-cycle protocol compare and directed + random scenarios.
module tb_ili9341_cmd_decoder;

  localparam int W = 240;
  localparam int H = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic        fifo_read_enable;
  logic [8:0]  fifo_read_data = 9'd0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_data;
  logic        display_on;

  int errors = 0;
  int checks = 0;
  int pop_count = 0;
  int ready_mode = 1;

  logic [8:0]  fifo_q[$];
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  int m_cmd, m_pidx, m_sc, m_ec, m_sp, m_ep, m_x, m_y;
  bit m_half, m_disp;
  logic [7:0] m_hi;
  logic [7:0] m_p[4];

  ili9341_cmd_decoder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_data         (pix_data),
    .display_on       (display_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the byte stream means, one byte at a time.
  function automatic void model_reset();
    m_cmd = 0; m_pidx = 0; m_half = 1'b0; m_hi = 8'd0;
    m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
    m_x = 0; m_y = 0;
`ifdef ILI_DISPCTL_EN
    m_disp = 1'b0;
`else
    m_disp = 1'b1;
`endif
  endfunction

  function automatic void model_byte(input logic [8:0] b);
    int s, e;
    if (!b[8]) begin
      m_cmd = int'(b[7:0]); m_pidx = 0; m_half = 1'b0;
      if (b[7:0] == 8'h01) begin
        m_cmd = 0; m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
`ifdef ILI_DISPCTL_EN
        m_disp = 1'b0;
`endif
      end else if (b[7:0] == 8'h2C) begin
        m_x = m_sc; m_y = m_sp;
      end
`ifdef ILI_DISPCTL_EN
      else if (b[7:0] == 8'h29) m_disp = 1'b1;
      else if (b[7:0] == 8'h28) m_disp = 1'b0;
`endif
    end else if (m_cmd == 'h2A || m_cmd == 'h2B) begin
      if (m_pidx < 4) begin
        m_p[m_pidx] = b[7:0];
        m_pidx++;
        if (m_pidx == 4) begin
          s = (int'(m_p[0]) * 256 + int'(m_p[1])) % 512;
          e = (int'(m_p[2]) * 256 + int'(m_p[3])) % 512;
          if (m_cmd == 'h2A) begin m_sc = s; m_ec = e; end
          else begin m_sp = s; m_ep = e; end
        end
      end
    end else if (m_cmd == 'h2C) begin
      if (!m_half) begin
        m_hi = b[7:0]; m_half = 1'b1;
      end else begin
        m_half = 1'b0;
        exp_q.push_back({9'(m_x), 9'(m_y), m_hi, b[7:0]});
        if (m_x == m_ec) begin
          m_x = m_sc;
          m_y = (m_y == m_ep) ? m_sp : (m_y + 1) % 512;
        end else begin
          m_x = (m_x + 1) % 512;
        end
      end
    end
  endfunction

  task automatic send(input logic [8:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  // FIFO and pixel sink emulation: sample the pop request mid-cycle, update after the edge.
  always begin
    logic pop;
    @(negedge clk);
    pop = fifo_read_enable;
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) fifo_read_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    case (ready_mode)
      0: pix_ready = 1'b0;
      1: pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b1;
    endcase
  end

  logic        prev_stall = 1'b0;
  logic [33:0] prev_pix = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("pop_blocked", 40'(fifo_read_enable & (fifo_empty | pix_valid)), 40'(0));
      if (fifo_read_enable) pop_count++;
      if (prev_stall)
        check("stall_hold", 40'({pix_valid, pix_x, pix_y, pix_data}), 40'({1'b1, prev_pix}));
      if (pix_valid && pix_ready) begin
        got_q.push_back({pix_x, pix_y, pix_data});
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pixel_extra: got x=%0d y=%0d d=0x%h, none required", pix_x, pix_y, pix_data);
        end else begin
          check("pixel", 40'({pix_x, pix_y, pix_data}), 40'(exp_q.pop_front()));
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = {pix_x, pix_y, pix_data};
    end
`ifndef ILI_DISPCTL_EN
    check("display_on_tied", 40'(display_on), 40'(1));
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    int n = 0;
    ready_mode = 1;
    while (quiet < 8 && n < 4000) begin
      tick(1);
      n++;
      if (fifo_q.size() == 0 && !pix_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) begin
      checks++; errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
    check({name, "_left"}, 40'(exp_q.size()), 40'(0));
    check({name, "_disp"}, 40'(display_on), 40'(m_disp));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!pix_valid && n < 300) begin
      tick(1);
      n++;
    end
    if (!pix_valid) begin
      checks++; errors++;
      $display("FAIL %s_wait: pix_valid=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic expect_px(input string name, input int idx, input int x, input int y);
    logic [33:0] g;
    if (idx >= got_q.size()) begin
      checks++; errors++;
      $display("FAIL %s: got %0d pixels, required index %0d", name, got_q.size(), idx);
    end else begin
      g = got_q[idx];
      check(name, 40'(g[33:16]), 40'({9'(x), 9'(y)}));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, pc, k, nd;
    logic [7:0] op;
    logic [33:0] e0;
    model_reset();
    rst = 1'b1;
    tick(3);
    check("rst_valid", 40'(pix_valid), 40'(0));
    check("rst_pop", 40'(fifo_read_enable), 40'(0));
    check("rst_xy", 40'({pix_x, pix_y}), 40'(0));
    check("rst_data", 40'(pix_data), 40'(0));
`ifdef ILI_DISPCTL_EN
    check("rst_disp", 40'(display_on), 40'(0));
`else
    check("rst_disp", 40'(display_on), 40'(1));
`endif
    rst = 1'b0;
    tick(2);

    // Single pixel at the origin after reset.
    gb = got_q.size();
    send(9'h02C); send(9'h1F8); send(9'h100);
    check("t1_model_n", 40'(exp_q.size()), 40'(1));
    if (exp_q.size() > 0) begin
      e0 = exp_q[0];
      check("t1_model", 40'(e0), 40'({9'd0, 9'd0, 16'hF800}));
    end
    drain("t1");
    check("t1_n", 40'(got_q.size() - gb), 40'(1));
    if (got_q.size() > gb) begin
      e0 = got_q[gb];
      check("t1_px", 40'(e0), 40'({9'd0, 9'd0, 16'hF800}));
    end

    // 2x2 window, five pixels wrapping back to the top-left corner.
    gb = got_q.size();
    send(9'h02A); send(9'h100); send(9'h10A); send(9'h100); send(9'h10B);
    send(9'h02B); send(9'h100); send(9'h105); send(9'h100); send(9'h106);
    send(9'h02C);
    for (int i = 0; i < 10; i++) send({1'b1, 8'($urandom_range(0, 255))});
    check("t2_model_n", 40'(exp_q.size()), 40'(5));
    drain("t2");
    expect_px("t2_px0", gb + 0, 10, 5);
    expect_px("t2_px1", gb + 1, 11, 5);
    expect_px("t2_px2", gb + 2, 10, 6);
    expect_px("t2_px3", gb + 3, 11, 6);
    expect_px("t2_px4", gb + 4, 10, 5);

    // Half pixel broken by a NOP produces nothing.
    gb = got_q.size();
    send(9'h02C); send(9'h1AA); send(9'h000); send(9'h1BB); send(9'h1CC);
    drain("t3");
    check("t3_none", 40'(got_q.size() - gb), 40'(0));

    // Truncated CASET leaves the old window.
    gb = got_q.size();
    send(9'h02A); send(9'h100); send(9'h132);
    send(9'h02C); send(9'h1AB); send(9'h1CD);
    drain("t4");
    check("t4_n", 40'(got_q.size() - gb), 40'(1));
    expect_px("t4_px", gb, 10, 5);

    // Sink stalls for 20 cycles: outputs hold, FIFO is not popped.
    ready_mode = 0;
    send(9'h02C); send(9'h112); send(9'h134); send(9'h156); send(9'h178);
    wait_valid("t5");
    pc = pop_count;
    tick(20);
    check("t5_nopop", 40'(pop_count), 40'(pc));
    check("t5_valid", 40'(pix_valid), 40'(1));
    check("t5_data", 40'(pix_data), 40'(16'h1234));
    drain("t5");

    // Inverted column window 510..1 wraps through 511 -> 0; PASET extras ignored.
    gb = got_q.size();
    send(9'h02A); send(9'h101); send(9'h1FE); send(9'h100); send(9'h101);
    send(9'h02B); send(9'h1FE); send(9'h100); send(9'h100); send(9'h100);
    send(9'h1FF); send(9'h1FF);
    send(9'h02C);
    for (int i = 0; i < 10; i++) send({1'b1, 8'($urandom_range(0, 255))});
    drain("t6");
    expect_px("t6_px0", gb + 0, 510, 0);
    expect_px("t6_px1", gb + 1, 511, 0);
    expect_px("t6_px2", gb + 2, 0, 0);
    expect_px("t6_px3", gb + 3, 1, 0);
    expect_px("t6_px4", gb + 4, 510, 0);

    // SWRESET restores the full window and drops the buffered half pixel.
    gb = got_q.size();
    send(9'h02C); send(9'h111); send(9'h001); send(9'h02C); send(9'h122); send(9'h133);
    drain("t7");
    check("t7_n", 40'(got_q.size() - gb), 40'(1));
    if (got_q.size() > gb) begin
      e0 = got_q[gb];
      check("t7_px", 40'(e0), 40'({9'd0, 9'd0, 16'h2233}));
    end

`ifdef ILI_DISPCTL_EN
    send(9'h029); drain("t8a");
    check("t8_on", 40'(display_on), 40'(1));
    send(9'h028); drain("t8b");
    check("t8_off", 40'(display_on), 40'(0));
    send(9'h029); send(9'h001); drain("t8c");
    check("t8_swrst", 40'(display_on), 40'(0));
`else
    send(9'h029); send(9'h028); send(9'h001); drain("t8");
    check("t8_on", 40'(display_on), 40'(1));
`endif

    // Randomized command/data mix against the model.
    for (int it = 0; it < 48; it++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: op = 8'h2A;
        1: op = 8'h2B;
        2, 3, 4: op = 8'h2C;
        5: op = 8'h00;
        6: op = 8'h01;
        7: op = 8'h28;
        8: op = 8'h29;
        default: op = 8'h55;
      endcase
      send({1'b0, op});
      nd = (op == 8'h2C) ? $urandom_range(0, 9) : $urandom_range(0, 6);
      for (int j = 0; j < nd; j++) send({1'b1, 8'($urandom_range(0, 255))});
      if (it % 4 == 3) drain("rnd");
    end
    drain("rnd_end");

    // Reset while a pixel is pending and more bytes are queued.
    ready_mode = 0;
    send(9'h02C);
    for (int i = 0; i < 6; i++) send({1'b1, 8'($urandom_range(0, 255))});
    wait_valid("t9");
    pc = pop_count;
    rst = 1'b1;
    tick(1);
    fifo_q.delete();
    exp_q.delete();
    model_reset();
    tick(2);
    check("t9_valid", 40'(pix_valid), 40'(0));
    check("t9_xy", 40'({pix_x, pix_y}), 40'(0));
    check("t9_nopop", 40'(pop_count), 40'(pc));
    rst = 1'b0;
    ready_mode = 1;
    tick(2);
    gb = got_q.size();
    send(9'h02C); send(9'h1F8); send(9'h100);
    drain("t9r");
    check("t9r_n", 40'(got_q.size() - gb), 40'(1));
    if (got_q.size() > gb) begin
      e0 = got_q[gb];
      check("t9r_px", 40'(e0), 40'({9'd0, 9'd0, 16'hF800}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
